// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants for the 640x480 @ 60 Hz text-overlay controller:
//   - horizontal / vertical timing (visible, front porch, sync, back porch)
//   - derived counter limits and sync windows as 10-bit values
//   - text overlay origin and the 8x8 glyph ROM for the message "HOLA"
//   - glyph_bit(): looks up one pixel of one glyph (MSB = leftmost pixel)
// ---------------------------------------------------------------------------
package vga_pkg;

    typedef logic [9:0] coord_t;
    typedef logic [2:0] rgb_t;

    // Horizontal timing in pixels
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;    // 800

    // Vertical timing in lines
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;    // 525

    // Counter limits and sync windows (inclusive bounds)
    localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_END    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_END    = coord_t'(V_VISIBLE);
    localparam coord_t H_SYNC_FIRST = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t H_SYNC_LAST  = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam coord_t V_SYNC_FIRST = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t V_SYNC_LAST  = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    // Text overlay: 4 glyphs of 8x8, each pixel doubled in both directions
    localparam int TXT_X     = 288;
    localparam int TXT_Y     = 232;
    localparam int TXT_CHARS = 4;
    localparam int GLYPH_DIM = 8;
    localparam int TXT_SCALE = 2;

    localparam coord_t TXT_X0    = coord_t'(TXT_X);
    localparam coord_t TXT_X_END = coord_t'(TXT_X + TXT_CHARS * GLYPH_DIM * TXT_SCALE); // exclusive
    localparam coord_t TXT_Y0    = coord_t'(TXT_Y);
    localparam coord_t TXT_Y_END = coord_t'(TXT_Y + GLYPH_DIM * TXT_SCALE);             // exclusive

    // Glyph ROM: [character][row], bit 7 of each row is the leftmost pixel
    localparam logic [7:0] GLYPH_ROM [TXT_CHARS][GLYPH_DIM] = '{
        '{8'hC3, 8'hC3, 8'hC3, 8'hFF, 8'hFF, 8'hC3, 8'hC3, 8'hC3},   // H
        '{8'h3C, 8'h66, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'h66, 8'h3C},   // O
        '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hFF},   // L
        '{8'h18, 8'h3C, 8'h66, 8'hC3, 8'hFF, 8'hC3, 8'hC3, 8'hC3}    // A
    };

    // col counts pixels from the left edge of the glyph, so it is mirrored
    // onto the bit index (leftmost pixel = bit 7).
    function automatic logic glyph_bit(input logic [1:0] ch,
                                       input logic [2:0] row,
                                       input logic [2:0] col);
        logic [7:0] glyph_row;
        glyph_row = GLYPH_ROM[ch][row];
        return glyph_row[3'd7 - col];
    endfunction

endpackage

// File: rtl/vga_sync.sv
// ---------------------------------------------------------------------------
// vga_sync
// Pixel-tick divider and raster counters for 640x480 @ 60 Hz from a 50 MHz
// clock. A toggle register produces a tick on every second clk; the
// horizontal counter advances on each tick and the vertical counter advances
// when the horizontal counter wraps.
//
// Ports:
//   clk          in   50 MHz clock, rising edge
//   reset        in   synchronous active-high reset (h=0, v=0, tick phase 0)
//   frame_start  out  tick at h=0, v=0 (only when FRAME_LATCH_EN is defined)
//   hsync_raw    out  combinational hsync, active low
//   vsync_raw    out  combinational vsync, active low
//   video_on     out  current position is in the visible area
//   in_text      out  current position is inside the text window
//   text_col     out  pixel column inside the window in glyph units (0..31)
//   text_row     out  glyph row inside the window (0..7)
// ---------------------------------------------------------------------------
module vga_sync
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
`ifdef FRAME_LATCH_EN
    output logic       frame_start,
`endif
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       video_on,
    output logic       in_text,
    output logic [4:0] text_col,
    output logic [2:0] text_row
);

    logic   tick_reg;
    logic   tick_next;
    coord_t h_reg;
    coord_t h_next;
    coord_t v_reg;
    coord_t v_next;

    // Counters only move on the cycle where the tick register is high, so
    // the first advance happens on the second clk after reset release.
    always_comb begin
        tick_next = ~tick_reg;
        h_next    = h_reg;
        v_next    = v_reg;
        if (tick_reg) begin
            if (h_reg == H_LAST) begin
                h_next = '0;
                if (v_reg == V_LAST) begin
                    v_next = '0;
                end else begin
                    v_next = v_reg + 10'd1;
                end
            end else begin
                h_next = h_reg + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_reg <= 1'b0;
            h_reg    <= '0;
            v_reg    <= '0;
        end else begin
            tick_reg <= tick_next;
            h_reg    <= h_next;
            v_reg    <= v_next;
        end
    end

    assign hsync_raw = !((h_reg >= H_SYNC_FIRST) && (h_reg <= H_SYNC_LAST));
    assign vsync_raw = !((v_reg >= V_SYNC_FIRST) && (v_reg <= V_SYNC_LAST));
    assign video_on  = (h_reg < H_VIS_END) && (v_reg < V_VIS_END);

    assign in_text = (h_reg >= TXT_X0) && (h_reg < TXT_X_END) &&
                     (v_reg >= TXT_Y0) && (v_reg < TXT_Y_END);

    // Halving the offset undoes the 2x magnification. Outside the window the
    // values are meaningless and are masked by in_text.
    assign text_col = 5'((h_reg - TXT_X0) >> 1);
    assign text_row = 3'((v_reg - TXT_Y0) >> 1);

`ifdef FRAME_LATCH_EN
    assign frame_start = tick_reg && (h_reg == '0) && (v_reg == '0);
`endif

endmodule

// File: rtl/controlador_vga.sv
// ---------------------------------------------------------------------------
// controlador_vga
// VGA text-overlay controller, 640x480 @ 60 Hz from a 50 MHz clock. Renders
// "HOLA" (8x8 glyphs scaled x2) centred on screen in the colour chosen by
// the switches. All outputs are registered one clk after the counter state.
//
// Build option:
//   FRAME_LATCH_EN  defined   -> switches captured only at frame start
//                               (tick with h=0, v=0), so no tearing
//                   undefined -> switches registered every clk
//
// Ports:
//   clk          in   50 MHz clock, rising edge
//   reset        in   synchronous active-high reset
//   rgbswitches  in   text colour [2]=red [1]=green [0]=blue
//   rgbtext      out  registered pixel colour, same bit order
//   hsync        out  registered horizontal sync, active low
//   vsync        out  registered vertical sync, active low
// ---------------------------------------------------------------------------
module controlador_vga
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] rgbswitches,
    output logic [2:0] rgbtext,
    output logic       hsync,
    output logic       vsync
);

    logic       hsync_raw;
    logic       vsync_raw;
    logic       video_on;
    logic       in_text;
    logic [4:0] text_col;
    logic [2:0] text_row;
`ifdef FRAME_LATCH_EN
    logic       frame_start;
`endif

    vga_sync u_sync (
        .clk         (clk),
        .reset       (reset),
`ifdef FRAME_LATCH_EN
        .frame_start (frame_start),
`endif
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw),
        .video_on    (video_on),
        .in_text     (in_text),
        .text_col    (text_col),
        .text_row    (text_row)
    );

    rgb_t colour_reg;
    rgb_t colour_next;
    rgb_t rgbtext_reg;
    rgb_t rgbtext_next;
    logic hsync_reg;
    logic vsync_reg;
    logic pixel_lit;

    always_comb begin
        colour_next = colour_reg;
`ifdef FRAME_LATCH_EN
        if (frame_start) begin
            colour_next = rgbswitches;
        end
`else
        colour_next = rgbswitches;
`endif
    end

    // text_col[4:3] selects the character, text_col[2:0] the column in it.
    assign pixel_lit = video_on && in_text &&
                       glyph_bit(text_col[4:3], text_row, text_col[2:0]);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rgb
            assign rgbtext_next[gi] = pixel_lit & colour_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            colour_reg  <= '0;
            rgbtext_reg <= '0;
            hsync_reg   <= 1'b1;
            vsync_reg   <= 1'b1;
        end else begin
            colour_reg  <= colour_next;
            rgbtext_reg <= rgbtext_next;
            hsync_reg   <= hsync_raw;
            vsync_reg   <= vsync_raw;
        end
    end

    assign rgbtext = rgbtext_reg;
    assign hsync   = hsync_reg;
    assign vsync   = vsync_reg;

endmodule

// File: tb/tb_controlador_vga.sv
// ---------------------------------------------------------------------------
// tb_controlador_vga
// Self-checking bench for controlador_vga. Every clk the outputs are
// compared with a reference model that derives the raster position from the
// number of clk edges since reset release (one pixel per two clk), so it
// does not replay the counter logic. To reach distant lines quickly the
// vertical counter is occasionally overridden for one clk, and the model's
// line offset is moved by the same amount. Colour switches change at random
// times during the text lines.
// ---------------------------------------------------------------------------
module tb_controlador_vga;

    localparam int LINE  = 800;
    localparam int FRAME = 800 * 525;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] rgbswitches = 3'b000;
    logic [2:0] rgbtext;
    logic       hsync;
    logic       vsync;

    controlador_vga dut (
        .clk         (clk),
        .reset       (reset),
        .rgbswitches (rgbswitches),
        .rgbtext     (rgbtext),
        .hsync       (hsync),
        .vsync       (vsync)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference glyphs for "HOLA", row 0 at top, bit 7 leftmost
    logic [7:0] font [4][8] = '{
        '{8'b11000011, 8'b11000011, 8'b11000011, 8'b11111111,
          8'b11111111, 8'b11000011, 8'b11000011, 8'b11000011},
        '{8'b00111100, 8'b01100110, 8'b11000011, 8'b11000011,
          8'b11000011, 8'b11000011, 8'b01100110, 8'b00111100},
        '{8'b11000000, 8'b11000000, 8'b11000000, 8'b11000000,
          8'b11000000, 8'b11000000, 8'b11111111, 8'b11111111},
        '{8'b00011000, 8'b00111100, 8'b01100110, 8'b11000011,
          8'b11111111, 8'b11000011, 8'b11000011, 8'b11000011}
    };

    // Model state: clk edges since release, pixel offset from overrides,
    // and the colour the DUT should currently be holding.
    int         edges    = 0;
    int         offset   = 0;
    logic [2:0] colour_m = 3'b000;
    int         lit_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Linear pixel index (v*800+h) of the counters before the next edge
    function automatic int cur_pixel();
        return (edges / 2 + offset) % FRAME;
    endfunction

    task automatic step();
        int         p, h, v, col, row;
        logic       exp_hs, exp_vs;
        logic [2:0] exp_rgb;
        @(posedge clk);
        if (reset) begin
            exp_hs   = 1'b1;
            exp_vs   = 1'b1;
            exp_rgb  = 3'b000;
            edges    = 0;
            offset   = 0;
            colour_m = 3'b000;
        end else begin
            p = cur_pixel();
            h = p % LINE;
            v = p / LINE;
            exp_hs  = !(h >= 656 && h <= 751);
            exp_vs  = !(v >= 490 && v <= 491);
            exp_rgb = 3'b000;
            if (h >= 288 && h < 352 && v >= 232 && v < 248) begin
                col = (h - 288) / 2;
                row = (v - 232) / 2;
                if (font[col / 8][row][7 - (col % 8)]) begin
                    exp_rgb = colour_m;
                    lit_seen++;
                end
            end
`ifdef FRAME_LATCH_EN
            if ((edges % 2) == 1 && p == 0) colour_m = rgbswitches;
`else
            colour_m = rgbswitches;
`endif
            edges++;
        end
        @(negedge clk);
        check("hsync", hsync, exp_hs);
        check("vsync", vsync, exp_vs);
        check("rgbtext", rgbtext, exp_rgb);
    endtask

    // sel 0 = hsync, 1 = vsync; returns edges taken to reach lvl (or bound)
    task automatic count_until(input int sel, input logic lvl, input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while ((((sel == 0) ? hsync : vsync) !== lvl) && (n < bound));
    endtask

    // Keep the override away from a horizontal wrap
    task automatic settle_h();
        while ((cur_pixel() % LINE) >= 790) step();
    endtask

    task automatic model_jump_v(input int nv);
        int p, np;
        p = cur_pixel();
        np = nv * LINE + (p % LINE);
        offset = (offset + np - p + FRAME) % FRAME;
    endtask

    initial begin
        int n, n2;

        // ---- reset held 3 clk ----
        reset       = 1'b1;
        rgbswitches = 3'b100;
        @(negedge clk);
        repeat (3) step();
        $display("reset held 3 clk: hsync=%0b vsync=%0b rgbtext=%03b", hsync, vsync, rgbtext);

        // ---- release, first line timing ----
        reset = 1'b0;
        count_until(0, 1'b0, 4000, n);
        check("first_hsync_fall", n, 1313);
        $display("first hsync fall after %0d clk", n);
        count_until(0, 1'b1, 400, n);
        check("hsync_low_width", n, 192);
        $display("hsync low width %0d clk", n);
        count_until(0, 1'b0, 2000, n2);
        check("hsync_period", n + n2, 1600);
        $display("hsync period %0d clk", n + n2);

        // ---- text window, red then random colours ----
        settle_h();
        model_jump_v(231);
        force dut.u_sync.v_reg = 10'd231;
        step();
        release dut.u_sync.v_reg;
        for (int ln = 0; ln < 17; ln++) begin
            if (ln >= 3) begin
                n = int'($urandom_range(20, 1580));
                repeat (n) step();
                if (ln == 5)       rgbswitches = 3'b010;
                else if (ln == 10) rgbswitches = 3'b001;
                else               rgbswitches = 3'($urandom_range(1, 7));
                repeat (1600 - n) step();
            end else begin
                repeat (1600) step();
            end
            $display("text line %0d done, switches now %03b, lit pixels so far %0d", 231 + ln, rgbswitches, lit_seen);
        end

        // ---- vertical sync with all colours on (blanking must stay dark) ----
        rgbswitches = 3'b111;
        settle_h();
        model_jump_v(487);
        force dut.u_sync.v_reg = 10'd487;
        step();
        release dut.u_sync.v_reg;
        count_until(1, 1'b0, 8000, n);
        check("vsync_fall_seen", vsync, 1'b0);
        count_until(0, 1'b0, 2000, n);
        check("vsync_to_hsync_fall", n, 1312);
        count_until(1, 1'b1, 4000, n2);
        check("vsync_low_width", n + n2, 3200);
        $display("vsync low width %0d clk, hsync fall %0d clk after vsync fall", n + n2, n);

        // ---- frame wrap 524 -> 0 ----
        settle_h();
        rgbswitches = 3'b010;
        model_jump_v(523);
        force dut.u_sync.v_reg = 10'd523;
        step();
        release dut.u_sync.v_reg;
        repeat (3 * 1600) step();
        $display("frame wrap crossed, switches %03b", rgbswitches);

        // ---- reset in mid-frame ----
        settle_h();
        model_jump_v(300);
        force dut.u_sync.v_reg = 10'd300;
        step();
        release dut.u_sync.v_reg;
        repeat (700) step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        count_until(0, 1'b0, 4000, n);
        check("restart_hsync_fall", n, 1313);
        count_until(0, 1'b1, 400, n2);
        check("restart_hsync_width", n2, 192);
        $display("mid-frame reset: hsync fall after %0d clk, width %0d clk", n, n2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
